descaler: RTL and testbench

Reverse path of the PC-to-drone scaling chain. The block takes a 15-bit scaled actuator/pulse value and divides it by the fixed scale constant with a sequential restoring divider. It then re-applies the 128-centred offset and saturates the result to one byte for the telemetry serializer (UART transmit side). It decodes what the scaler encodes: `source_data = (byte + offset - 128) * 48` becomes `byte = value / 48 + 128 - offset`.

---
 rtl/descaler_if.sv | 34 +++
 rtl/descaler.sv | 125 ++++++++++++
 tb/tb_descaler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/descaler_if.sv
// Handshake bundle for the descaler: scaled value in on the sink side,
// recovered byte out on the source side, plus a busy status flag.
interface descaler_if;
   logic        sink_data_valid;
   logic [14:0] sink_data;
   logic [7:0]  sink_offset;
   logic        sink_ready;
   logic        source_data_valid;
   logic        source_ready;
   logic [7:0]  source_data;
   logic        busy;

   modport slave (
      input  sink_data_valid,
      input  sink_data,
      input  sink_offset,
      input  source_ready,
      output sink_ready,
      output source_data_valid,
      output source_data,
      output busy
   );

   modport master (
      output sink_data_valid,
      output sink_data,
      output sink_offset,
      output source_ready,
      input  sink_ready,
      input  source_data_valid,
      input  source_data,
      input  busy
   );
endinterface

// File: rtl/descaler.sv
// Recovers a byte from a scaled value: sequential restoring divide by CONSTANT_VAL,
// re-apply the 128-centred offset, saturate to 8 bits. DESCALER_ROUND_EN enables round-to-nearest.
module descaler #(
   parameter logic [14:0] CONSTANT_VAL = 15'd48
) (
   input logic       clk,
   input logic       reset,
   descaler_if.slave bus
);

   if (CONSTANT_VAL == 15'd0) begin : g_bad_divisor
      $error("descaler: CONSTANT_VAL must be in 1..32767");
   end

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      ADJ,
      OUT
   } state_t;

   state_t       state;
   state_t       state_next;

   logic [14:0]  dividend;
   logic [7:0]   offset;
   logic [14:0]  quot;
   logic [14:0]  rem;
   logic [3:0]   bit_cnt;
   logic [7:0]   data_reg;
   logic         valid_reg;

   logic [15:0]  rem_shift;
   logic         step_ge;
   logic [14:0]  rem_next;
   logic [15:0]  q_final;
   logic signed [16:0] sum;
   logic [7:0]   result;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.sink_data_valid) state_next = DIV;
         DIV:  if (bit_cnt == 4'd0)     state_next = ADJ;
         ADJ:                           state_next = OUT;
         OUT:  if (bus.source_ready)    state_next = IDLE;
         default:                       state_next = IDLE;
      endcase
   end

   // Dividend shifts left each step so its MSB is always the next bit to bring down.
   always_comb begin
      rem_shift = {rem, dividend[14]};
      step_ge   = rem_shift >= {1'b0, CONSTANT_VAL};
      rem_next  = step_ge ? 15'(rem_shift - {1'b0, CONSTANT_VAL}) : rem_shift[14:0];
   end

   always_comb begin
`ifdef DESCALER_ROUND_EN
      q_final = {1'b0, quot} + {15'd0, ({rem, 1'b0} >= {1'b0, CONSTANT_VAL})};
`else
      q_final = {1'b0, quot};
`endif
      sum = $signed({1'b0, q_final}) + 17'sd128 - $signed({9'd0, offset});
      if (sum[16]) begin
         result = 8'd0;
      end else if (sum > 17'sd255) begin
         result = 8'd255;
      end else begin
         result = sum[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dividend  <= 15'd0;
         offset    <= 8'd0;
         quot      <= 15'd0;
         rem       <= 15'd0;
         bit_cnt   <= 4'd0;
         data_reg  <= 8'd0;
         valid_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.sink_data_valid) begin
                  dividend <= bus.sink_data;
                  offset   <= bus.sink_offset;
                  quot     <= 15'd0;
                  rem      <= 15'd0;
                  bit_cnt  <= 4'd14;
               end
            end
            DIV: begin
               dividend <= {dividend[13:0], 1'b0};
               rem      <= rem_next;
               quot     <= {quot[13:0], step_ge};
               if (bit_cnt != 4'd0) bit_cnt <= bit_cnt - 4'd1;
            end
            ADJ: begin
               data_reg  <= result;
               valid_reg <= 1'b1;
            end
            OUT: begin
               if (bus.source_ready) valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.sink_ready        = (state == IDLE);
   assign bus.busy              = (state != IDLE);
   assign bus.source_data_valid = valid_reg;
   assign bus.source_data       = data_reg;

endmodule

// File: tb/tb_descaler.sv
// Directed self-checking bench for descaler: decode, saturation, rounding,
// backpressure, back-to-back throughput and reset during a divide.
module tb_descaler;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   descaler_if bus_if ();

   descaler #(.CONSTANT_VAL(15'd48)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Called at a negedge; returns just after the accept edge (edge 0).
   task automatic applyStimulus(input logic [14:0] d, input logic [7:0] o);
      int guard;
      guard = 0;
      while (!bus_if.sink_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("sink_ready_wait", int'(bus_if.sink_ready), 1);
      bus_if.sink_data       = d;
      bus_if.sink_offset     = o;
      bus_if.sink_data_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.sink_data_valid = 1'b0;
   endtask

   // Index k is the negedge following edge k.
   task automatic waitResult(output int found, output int edges, output int data);
      found = 0;
      edges = -1;
      data  = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus_if.source_data_valid) begin
            found = 1;
            edges = k;
            data  = int'(bus_if.source_data);
            break;
         end
      end
   endtask

   task automatic runJob(input string tag, input logic [14:0] d, input logic [7:0] o, input int expected);
      int found, edges, data;
      applyStimulus(d, o);
      waitResult(found, edges, data);
      checkOutput({tag, "_seen"}, found, 1);
      checkOutput({tag, "_data"}, data, expected);
      checkOutput({tag, "_latency"}, edges, 16);
      @(negedge clk);
      checkOutput({tag, "_done"}, int'({bus_if.source_data_valid, bus_if.sink_ready}), 1);
   endtask

   initial begin
      int found, edges, data;
      int t1, t2, d1, d2, seen_first, seen_second, ready_again, stale;
      checks   = 0;
      failures = 0;

      bus_if.sink_data_valid = 1'b0;
      bus_if.sink_data       = 15'd0;
      bus_if.sink_offset     = 8'd0;
      bus_if.source_ready    = 1'b1;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      checkOutput("rst_valid", int'(bus_if.source_data_valid), 0);
      checkOutput("rst_data", int'(bus_if.source_data), 0);
      checkOutput("rst_busy", int'(bus_if.busy), 0);
      checkOutput("rst_ready", int'(bus_if.sink_ready), 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      runJob("basic", 15'd480, 8'd128, 10);
      runJob("offset0", 15'd4800, 8'd0, 228);
      runJob("sat_hi", 15'd32767, 8'd0, 255);
      runJob("sat_lo", 15'd480, 8'd255, 0);
      runJob("round503", 15'd503, 8'd128, 10);
`ifdef DESCALER_ROUND_EN
      runJob("round504", 15'd504, 8'd128, 11);
`else
      runJob("round504", 15'd504, 8'd128, 10);
`endif

      bus_if.source_ready = 1'b0;
      applyStimulus(15'd960, 8'd128);
      waitResult(found, edges, data);
      checkOutput("bp_seen", found, 1);
      checkOutput("bp_data", data, 20);
      bus_if.sink_data       = 15'd48;
      bus_if.sink_offset     = 8'd0;
      bus_if.sink_data_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_hold_data", int'(bus_if.source_data), 20);
         checkOutput("bp_hold_valid", int'(bus_if.source_data_valid), 1);
         checkOutput("bp_hold_ready", int'(bus_if.sink_ready), 0);
      end
      bus_if.sink_data_valid = 1'b0;
      bus_if.source_ready    = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_valid", int'(bus_if.source_data_valid), 0);
      checkOutput("bp_release_ready", int'(bus_if.sink_ready), 1);
      @(negedge clk);
      checkOutput("bp_idle_busy", int'(bus_if.busy), 0);
      checkOutput("bp_keep_data", int'(bus_if.source_data), 20);

      t1 = -1; t2 = -1; d1 = -1; d2 = -1;
      seen_first = 0; seen_second = 0; ready_again = 0;
      bus_if.sink_data       = 15'd96;
      bus_if.sink_offset     = 8'd128;
      bus_if.sink_data_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.sink_data = 15'd144;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (bus_if.source_data_valid) begin
            if (seen_first == 0) begin
               seen_first = 1; t1 = k; d1 = int'(bus_if.source_data);
            end else if (k > t1 + 1) begin
               seen_second = 1; t2 = k; d2 = int'(bus_if.source_data);
               break;
            end
         end
         if (seen_first == 1 && bus_if.sink_ready) ready_again = 1;
         if (ready_again == 1 && !bus_if.sink_ready) bus_if.sink_data_valid = 1'b0;
      end
      bus_if.sink_data_valid = 1'b0;
      checkOutput("b2b_first_data", d1, 2);
      checkOutput("b2b_first_time", t1, 16);
      checkOutput("b2b_second_seen", seen_second, 1);
      checkOutput("b2b_second_data", d2, 3);
      checkOutput("b2b_spacing", t2 - t1, 18);
      repeat (2) @(negedge clk);
      checkOutput("b2b_idle", int'(bus_if.busy), 0);

      applyStimulus(15'd480, 8'd128);
      repeat (7) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checkOutput("mid_rst_valid", int'(bus_if.source_data_valid), 0);
      checkOutput("mid_rst_data", int'(bus_if.source_data), 0);
      checkOutput("mid_rst_busy", int'(bus_if.busy), 0);
      checkOutput("mid_rst_ready", int'(bus_if.sink_ready), 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      stale = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (bus_if.source_data_valid) stale++;
      end
      checkOutput("mid_rst_stale", stale, 0);
      runJob("post_rst", 15'd4800, 8'd0, 228);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
